// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl_pkg
//  Desc     : Shared ALU op encodings and HI/LO controller state encodings.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_ctrl_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_BUSY_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    BUSY = ST_BUSY_ENC,
    DONE = ST_DONE_ENC
  } state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Desc     : Radix-2 restoring divider datapath, one quotient bit per step.
//  Revision : 1.0  initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_fits;

  // The dividend shifts out of r_quo's MSB while quotient bits enter its LSB.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[WIDTH-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_count <= '0;
    end else if (start) begin
      r_rem   <= '0;
      r_quo   <= dividend;
      r_div   <= divisor;
      r_count <= '0;
    end else if (step) begin
      r_rem   <= w_fits ? w_sub : w_shift[WIDTH-1:0];
      r_quo   <= {r_quo[WIDTH-2:0], w_fits};
      r_count <= r_count + CW'(1);
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign ready     = step && (r_count == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Desc     : E-stage HI/LO controller: 1-cycle MULT/MULTU, iterative DIV/DIVU.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrolE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  output logic             stall_divE,
  output logic             hilo_weE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE,
  output logic             busyE
);

  state_t           r_state;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_raw_a;

  logic             w_is_mul;
  logic             w_is_sdiv;
  logic             w_is_div;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_start;
  logic             w_step;
  logic             w_ready;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_mul  = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
  assign w_is_sdiv = (alucontrolE == EXE_DIV_OP);
  assign w_is_div  = is_div_op(alucontrolE);

  // One 2W-bit multiplier serves both forms; sign extension selects MULT.
  assign w_mul_a = {{WIDTH{(alucontrolE == EXE_MULT_OP) & srcaE[WIDTH-1]}}, srcaE};
  assign w_mul_b = {{WIDTH{(alucontrolE == EXE_MULT_OP) & srcbE[WIDTH-1]}}, srcbE};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_neg_a = w_is_sdiv & srcaE[WIDTH-1];
  assign w_neg_b = w_is_sdiv & srcbE[WIDTH-1];
  assign w_abs_a = w_neg_a ? -srcaE : srcaE;
  assign w_abs_b = w_neg_b ? -srcbE : srcbE;

  assign w_start = (r_state == IDLE) && !flushE && w_is_div;
  assign w_step  = (r_state == BUSY) && !flushE;

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .step      (w_step),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .ready     (w_ready)
  );

  // The remainder follows the dividend's sign; the quotient is negated on mixed signs.
  assign w_q_fix = r_neg_q ? -w_quo : w_quo;
  assign w_r_fix = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_raw_a    <= '0;
    end else if (flushE) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_div) begin
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_div_zero <= (srcbE == '0);
            r_raw_a    <= srcaE;
            r_state    <= (srcbE == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (w_ready) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_divE = 1'b0;
    hilo_weE   = 1'b0;
    hiE        = '0;
    loE        = '0;
    if (!flushE) begin
      case (r_state)
        IDLE: begin
          if (w_is_mul) begin
            hilo_weE   = 1'b1;
            {hiE, loE} = w_prod;
          end else if (w_is_div) begin
            stall_divE = 1'b1;
          end
        end
        BUSY: stall_divE = 1'b1;
        DONE: begin
          hilo_weE = 1'b1;
          hiE      = r_div_zero ? r_raw_a : w_r_fix;
          loE      = r_div_zero ? '1 : w_q_fix;
        end
        default: stall_divE = 1'b0;
      endcase
    end
  end

  assign busyE = (r_state == BUSY);

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage controller for HI/LO-producing instructions: MULT, MULTU, DIV, DIVU.
- MULT/MULTU complete in a single cycle.
- DIV/DIVU run on an iterative radix-2 restoring divider. While the divider is busy, the controller stalls the pipeline.
- Produces the HI/LO write strobe and data for the hilo register. Sits beside the ALU in the E stage and is driven by the E-stage alucontrol from aludec.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- alucontrolE  in  8  E-stage ALU op (EXE_*_OP encoding)
- srcaE  in  WIDTH  rs operand (dividend / multiplicand)
- srcbE  in  WIDTH  rt operand (divisor / multiplier)
- flushE  in  1  cancel the E-stage instruction (exception/branch flush)
- stall_divE  out  1  hold F/D/E stages; combinational from state and inputs
- hilo_weE  out  1  write HI/LO this cycle
- hiE  out  WIDTH  value for HI
- loE  out  WIDTH  value for LO
- busyE  out  1  divider in BUSY state

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, internal registers=0.
  - hilo_weE=0, stall_divE=0, busyE=0, hiE=loE=0.
  - A reset mid-division aborts the operation with no write.
- States: IDLE, BUSY, DONE.
- IDLE with MULT/MULTU (flushE=0):
  - hilo_weE=1 in the same cycle; {hiE,loE} = 2*WIDTH-bit product (signed for MULT, unsigned for MULTU).
  - No stall; state stays IDLE.
- IDLE with DIV/DIVU (flushE=0):
  - stall_divE=1 combinationally.
  - Latch |srcaE|, |srcbE| (raw values for DIVU), sign of quotient (sa^sb, DIV only) and sign of dividend.
  - Clear the partial remainder. Next state is BUSY, or DONE if srcbE==0.
- BUSY:
  - One restoring step per cycle: shift in the next dividend bit, trial-subtract, set the quotient bit.
  - counter increments from 0; after WIDTH steps (counter==WIDTH-1 this cycle) go to DONE.
  - stall_divE=1, busyE=1.
- DONE (one cycle):
  - stall_divE=0, hilo_weE=1, loE=quotient, hiE=remainder after sign fix-up. Next state is IDLE.
  - The DIV still present in alucontrolE during DONE must NOT restart the divider. The pipeline advances at the end of this cycle.
- Latency: start cycle T, BUSY T+1..T+WIDTH, DONE at T+WIDTH+1. With WIDTH=32 the instruction occupies E for 34 cycles.
- Sign rules (DIV):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero: no iteration; DONE at T+1 with hi=srcaE as latched (raw), lo=all ones. Same for DIV and DIVU.
- flushE=1:
  - In IDLE, no start and no write, even for MULT.
  - In BUSY or DONE, return to IDLE next cycle with no hilo_weE; stall_divE=0 in the flush cycle.
  - Flush has priority over every other transition.
- Non-muldiv ops in IDLE: all outputs 0.
- hiE/loE are don't-care when hilo_weE=0, but are driven to 0.

Decomposition:
- EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP and EXE_DIVU_OP stay in the shared defines.vh.
- State encodings (IDLE/BUSY/DONE) are added to defines.vh as localparams.
- One sub-module, div_iter: the registered restoring-division datapath (remainder/quotient shift registers, trial subtractor, step counter).
  - Its interface is start, step, operands and ready.
- muldiv_ctrl owns the FSM, sign handling, multiplier and flush/stall logic.

Test Plan:
- DIVU srca=7, srcb=2 -> stall_divE=1 for 33 cycles; hilo_weE=1 exactly once at T+33 with lo=3, hi=1; stall=0 that cycle; no restart.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> at T+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU srca=0x12345678, srcb=0 -> DONE at T+1, hi=0x12345678, lo=0xFFFFFFFF, stall asserted only in cycle T.
- MULT srca=0xFFFFFFFF, srcb=2 -> same cycle hilo_weE=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, stall=0. MULTU with the same operands -> hi=1, lo=0xFFFFFFFE.
- DIV in progress, flushE=1 at BUSY step 10 -> stall drops that cycle, state IDLE next cycle, no hilo_weE ever. Repeat with rst=1 mid-BUSY -> all outputs 0 next cycle.
- Back-to-back DIVU 100/7 then DIVU 9/3 -> two writes: (lo=14, hi=2) and (lo=3, hi=0), second start in the cycle after DONE, total 68 cycles.
